pipelined_accum_adder_tree: RTL and testbench

//  Pipelined, signed binary adder tree with one registered stage per tree level.

---
 rtl/pipelined_accum_adder_tree_pkg.sv | 50 +++++
 rtl/pipelined_accum_adder_tree_if.sv | 28 ++
 rtl/pipelined_accum_adder_tree_level.sv | 45 ++++
 rtl/pipelined_accum_adder_tree.sv | 130 +++++++++++++
 tb/tb_pipelined_accum_adder_tree.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_accum_adder_tree_pkg.sv
// Shared helpers for the pipelined accumulating adder tree.
//  clog2     : ceiling log2, used for the tree depth
//  tree_bits : exact width of a full tree sum (IN_BITS + LEVELS)
//  sat_add   : signed add clamped to a w-bit two's-complement range
//  sat_ovf   : 1 when sat_add had to clamp
// The saturation helpers are only used when PIPELINED_ACCUM_ADDER_TREE_SAT_EN
// is defined.
package pipelined_adder_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int tree_bits(input int in_bits, input int nodes);
        return in_bits + clog2(nodes);
    endfunction

    // Operands arrive sign-extended to 64 bits; the 64-bit sum cannot overflow
    // for any w <= 62, so the range test below is exact.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic logic sat_ovf(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int w);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/pipelined_accum_adder_tree_if.sv
// Beat/result handshake bundle for pipelined_accum_adder_tree.
//  in_valid/in_ready/in_last/addends : input beat channel (producer -> block)
//  out_valid/out_ready/sum_out/sat_flag : group-sum channel (block -> consumer)
// slave = the adder block, master = the surrounding logic / bench.
interface pipelined_accum_adder_tree_if #(
    parameter int IN_BITS   = 8,
    parameter int NUM_NODES = 4,
    parameter int ACC_BITS  = 24
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [IN_BITS*NUM_NODES-1:0]  addends;
    logic                          out_valid;
    logic                          out_ready;
    logic [ACC_BITS-1:0]           sum_out;
    logic                          sat_flag;

    modport slave (
        input  in_valid, in_last, addends, out_ready,
        output in_ready, out_valid, sum_out, sat_flag
    );

    modport master (
        output in_valid, in_last, addends, out_ready,
        input  in_ready, out_valid, sum_out, sat_flag
    );
endinterface

// File: rtl/pipelined_accum_adder_tree_level.sv
// One registered level of the adder tree.
//  PAIRS : number of adjacent pairs summed at this level
//  IN_W  : signed width of each incoming operand; results are IN_W+1 wide
// Ports: clk, rst (sync, active-high), advance (pipeline enable),
//        in_vld/in_last/in_data from the previous level,
//        out_vld/out_last/out_data towards the next level.
// Pair p sums operands 2p and 2p+1; everything holds while advance=0.
module adder_tree_level #(
    parameter int PAIRS = 2,
    parameter int IN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       in_vld,
    input  logic                       in_last,
    input  logic [2*PAIRS*IN_W-1:0]    in_data,
    output logic                       out_vld,
    output logic                       out_last,
    output logic [PAIRS*(IN_W+1)-1:0]  out_data
);
    logic [PAIRS*(IN_W+1)-1:0] sums;

    // Size casts of $signed operands sign-extend, so each pair sum is exact.
    always_comb begin
        sums = '0;
        for (int p = 0; p < PAIRS; p++) begin
            sums[p*(IN_W+1) +: IN_W+1] =
                (IN_W+1)'($signed(in_data[(2*p)*IN_W +: IN_W])) +
                (IN_W+1)'($signed(in_data[(2*p+1)*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_data <= '0;
        end else if (advance) begin
            out_vld  <= in_vld;
            out_last <= in_last;
            out_data <= sums;
        end
    end
endmodule

// File: rtl/pipelined_accum_adder_tree.sv
// Pipelined signed adder tree followed by a group accumulator.
//  clk, rst : single clock, synchronous active-high reset
//  bus      : pipelined_accum_adder_tree_if.slave
//             in_valid/in_ready/in_last/addends  beat input
//             out_valid/out_ready/sum_out/sat_flag group result
// LEVELS = clog2(NUM_NODES) registered tree levels, then one accumulator
// stage. The whole pipeline advances only when the output slot is free or
// being drained, and in_ready mirrors that enable.
// Optional feature macro: PIPELINED_ACCUM_ADDER_TREE_SAT_EN -- saturating
// accumulation with a per-group sat_flag; otherwise wraps and sat_flag=0.
module pipelined_accum_adder_tree
    import pipelined_adder_pkg::*;
#(
    parameter int IN_BITS   = 8,
    parameter int NUM_NODES = 4,
    parameter int ACC_BITS  = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    pipelined_accum_adder_tree_if.slave    bus
);
    localparam int LEVELS    = clog2(NUM_NODES);
    localparam int TREE_BITS = tree_bits(IN_BITS, NUM_NODES);

    if (NUM_NODES < 2 || (NUM_NODES & (NUM_NODES - 1)) != 0) begin : g_bad_nodes
        $error("NUM_NODES must be a power of 2 and >= 2");
    end
    if (ACC_BITS < TREE_BITS) begin : g_bad_acc
        $error("ACC_BITS must be >= IN_BITS + clog2(NUM_NODES)");
    end

    logic                        advance;
    logic [LEVELS:0]             vld_pipe;
    logic [LEVELS:0]             last_pipe;
    logic [TREE_BITS-1:0]        tree_sum;
    logic signed [ACC_BITS-1:0]  tree_ext;
    logic signed [ACC_BITS-1:0]  acc_q;
    logic signed [ACC_BITS-1:0]  acc_nxt;
    logic [ACC_BITS-1:0]         sum_q;
    logic                        out_valid_q;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance;
    assign vld_pipe[0]  = bus.in_valid;
    assign last_pipe[0] = bus.in_last;

    // Level l takes NUM_NODES>>l operands of IN_BITS+l bits each.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int W = IN_BITS + l;
        localparam int P = NUM_NODES >> (l + 1);
        logic [2*P*W-1:0]   d_in;
        logic [P*(W+1)-1:0] d_out;

        if (l == 0) begin : g_first
            assign d_in = bus.addends;
        end else begin : g_next
            assign d_in = g_lvl[l-1].d_out;
        end

        adder_tree_level #(.PAIRS(P), .IN_W(W)) u_level (
            .clk      (clk),
            .rst      (rst),
            .advance  (advance),
            .in_vld   (vld_pipe[l]),
            .in_last  (last_pipe[l]),
            .in_data  (d_in),
            .out_vld  (vld_pipe[l+1]),
            .out_last (last_pipe[l+1]),
            .out_data (d_out)
        );
    end

    assign tree_sum = g_lvl[LEVELS-1].d_out;
    assign tree_ext = ACC_BITS'($signed(tree_sum));

`ifdef PIPELINED_ACCUM_ADDER_TREE_SAT_EN
    logic clamp;
    logic grp_sat_q;
    logic sat_q;

    assign acc_nxt = ACC_BITS'(sat_add(64'(acc_q), 64'(tree_ext), ACC_BITS));
    assign clamp   = sat_ovf(64'(acc_q), 64'(tree_ext), ACC_BITS);

    // grp_sat_q remembers any clamp earlier in the open group.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_sat_q <= 1'b0;
            sat_q     <= 1'b0;
        end else if (advance && vld_pipe[LEVELS]) begin
            if (last_pipe[LEVELS]) begin
                sat_q     <= grp_sat_q || clamp;
                grp_sat_q <= 1'b0;
            end else begin
                grp_sat_q <= grp_sat_q || clamp;
            end
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign acc_nxt      = acc_q + tree_ext;
    assign bus.sat_flag = 1'b0;
`endif

    // A closing beat publishes acc+tree and restarts the group from zero, so
    // a new sum can replace one being drained on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            if (vld_pipe[LEVELS]) begin
                if (last_pipe[LEVELS]) begin
                    sum_q       <= acc_nxt;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                end else begin
                    acc_q       <= acc_nxt;
                    out_valid_q <= 1'b0;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_pipelined_accum_adder_tree.sv
// Bench for pipelined_accum_adder_tree: two instances (ACC_BITS=24 and 10)
// driven with identical beats; a group-level arithmetic model predicts every
// group sum and saturation flag.
module tb_pipelined_accum_adder_tree;

`ifdef PIPELINED_ACCUM_ADDER_TREE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_accum_adder_tree_if #(.IN_BITS(8), .NUM_NODES(4), .ACC_BITS(24)) bus24 ();
    pipelined_accum_adder_tree_if #(.IN_BITS(8), .NUM_NODES(4), .ACC_BITS(10)) bus10 ();

    pipelined_accum_adder_tree #(.IN_BITS(8), .NUM_NODES(4), .ACC_BITS(24)) u_dut (
        .clk (clk), .rst (rst), .bus (bus24)
    );
    pipelined_accum_adder_tree #(.IN_BITS(8), .NUM_NODES(4), .ACC_BITS(10)) u_dut10 (
        .clk (clk), .rst (rst), .bus (bus10)
    );

    int n_vec = 0;
    int n_err = 0;

    bit  cur_v = 1'b0, cur_last = 1'b0, cur_ordy = 1'b1;
    int  cur_ad[4] = '{0, 0, 0, 0};
    bit  accepted = 1'b0, ov_seen = 1'b0, hold_pend = 1'b0;
    logic [23:0] prev24;
    logic [9:0]  prev10;

    longint acc24 = 0, acc10 = 0;
    bit     s24 = 1'b0, s10 = 1'b0;
    longint q24[$], q10[$];
    bit     qf24[$], qf10[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Group accumulation rule: add, then wrap to or clamp at a bits-wide range.
    function automatic longint acc_step(input longint a, input longint s, input int bits,
                                        output bit hit);
        longint r, m, hi, lo;
        m  = longint'(1) << bits;
        hi = m / 2 - 1;
        lo = -(m / 2);
        r  = a + s;
        hit = 1'b0;
        if (SAT) begin
            if (r > hi) begin r = hi; hit = 1'b1; end
            else if (r < lo) begin r = lo; hit = 1'b1; end
        end else begin
            r = (r - lo) % m;
            if (r < 0) r += m;
            r += lo;
        end
        return r;
    endfunction

    function automatic int rnd();
        case ($urandom % 4)
            0:       return ($urandom % 2) ? 127 : -128;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    // New beat only once the previous one was taken (inputs stay stable on stall).
    task automatic offer(input bit v, input bit lst, input int a0, input int a1,
                         input int a2, input int a3);
        if (cur_v && !accepted) return;
        cur_v    = v;
        cur_last = lst;
        cur_ad   = '{a0, a1, a2, a3};
    endtask

    task automatic step(input bit r);
        longint s, e;
        bit h, f;
        logic [31:0] packed_ad;
        @(negedge clk);
        packed_ad = {8'(cur_ad[3]), 8'(cur_ad[2]), 8'(cur_ad[1]), 8'(cur_ad[0])};
        rst = r;
        bus24.in_valid = cur_v;  bus24.in_last = cur_last;
        bus24.addends = packed_ad; bus24.out_ready = cur_ordy;
        bus10.in_valid = cur_v;  bus10.in_last = cur_last;
        bus10.addends = packed_ad; bus10.out_ready = cur_ordy;
        #1;
        if (r) begin
            acc24 = 0; acc10 = 0; s24 = 1'b0; s10 = 1'b0;
            q24.delete(); q10.delete(); qf24.delete(); qf10.delete();
            accepted = 1'b0; hold_pend = 1'b0; ov_seen = 1'b0;
            return;
        end
        chk("in_ready", 64'(bus24.in_ready), 64'(!bus24.out_valid || cur_ordy));
        if (hold_pend) begin
            chk("hold24", 64'(bus24.sum_out), 64'(prev24));
            chk("hold10", 64'(bus10.sum_out), 64'(prev10));
        end
        if (bus24.out_valid && cur_ordy) begin
            chk("pending24", 64'(q24.size() != 0), 64'd1);
            if (q24.size() != 0) begin
                e = q24.pop_front(); f = qf24.pop_front();
                chk("sum24", 64'(bus24.sum_out), 64'(e) & 64'hFF_FFFF);
                chk("sat24", 64'(bus24.sat_flag), 64'(f));
            end
        end
        if (bus10.out_valid && cur_ordy) begin
            chk("pending10", 64'(q10.size() != 0), 64'd1);
            if (q10.size() != 0) begin
                e = q10.pop_front(); f = qf10.pop_front();
                chk("sum10", 64'(bus10.sum_out), 64'(e) & 64'h3FF);
                chk("sat10", 64'(bus10.sat_flag), 64'(f));
            end
        end
        hold_pend = bus24.out_valid && !cur_ordy;
        prev24 = bus24.sum_out;
        prev10 = bus10.sum_out;
        ov_seen = bus24.out_valid;
        accepted = cur_v && bus24.in_ready;
        if (accepted) begin
            s = cur_ad[0] + cur_ad[1] + cur_ad[2] + cur_ad[3];
            acc24 = acc_step(acc24, s, 24, h); s24 |= h;
            acc10 = acc_step(acc10, s, 10, h); s10 |= h;
            if (cur_last) begin
                q24.push_back(acc24); qf24.push_back(s24);
                q10.push_back(acc10); qf10.push_back(s10);
                acc24 = 0; acc10 = 0; s24 = 1'b0; s10 = 1'b0;
            end
        end
    endtask

    task automatic drain(input int n);
        cur_ordy = 1'b1;
        for (int i = 0; i < n; i++) begin
            offer(0, 0, 0, 0, 0, 0);
            step(0);
        end
    endtask

    initial begin
        bus24.in_valid = 1'b0; bus24.in_last = 1'b0; bus24.addends = '0; bus24.out_ready = 1'b1;
        bus10.in_valid = 1'b0; bus10.in_last = 1'b0; bus10.addends = '0; bus10.out_ready = 1'b1;

        // reset state
        step(1); step(1);
        offer(0, 0, 0, 0, 0, 0); step(0);
        chk("rst_ov", 64'(bus24.out_valid), 64'd0);
        chk("rst_sum", 64'(bus24.sum_out), 64'd0);
        chk("rst_sat", 64'(bus24.sat_flag), 64'd0);
        chk("rst_rdy", 64'(bus24.in_ready), 64'd1);
        chk("rst_ov10", 64'(bus10.out_valid), 64'd0);

        // single beat, latency LEVELS+1 edges
        offer(1, 1, 1, 2, 3, 4); step(0);
        offer(0, 0, 0, 0, 0, 0); step(0); chk("lat_t0", 64'(ov_seen), 64'd0);
        step(0); chk("lat_t1", 64'(ov_seen), 64'd0);
        step(0); chk("lat_t2", 64'(ov_seen), 64'd1);
        drain(3);

        // negative and positive extremes
        offer(1, 1, -128, -128, -128, -128); step(0);
        offer(1, 1, 127, 127, 127, 127); step(0);
        drain(6);

        // two-beat group: only one output
        offer(1, 0, 1, 1, 1, 1); step(0);
        offer(1, 1, 2, 2, 2, 2); step(0); chk("grp_ov0", 64'(ov_seen), 64'd0);
        offer(0, 0, 0, 0, 0, 0); step(0); chk("grp_ov1", 64'(ov_seen), 64'd0);
        step(0); chk("grp_ov2", 64'(ov_seen), 64'd0);
        step(0); chk("grp_ov3", 64'(ov_seen), 64'd1);
        drain(3);

        // backpressure with back-to-back single-beat groups
        for (int i = 0; i < 14; i++) begin
            cur_ordy = !(i >= 4 && i <= 6);
            offer(1, 1, i, i + 1, -i, 2);
            step(0);
        end
        drain(6);

        // reset in the middle of a group
        offer(1, 0, 5, 6, 7, 8); step(0);
        offer(1, 0, 9, 9, 9, 9); step(0);
        offer(0, 0, 0, 0, 0, 0); step(1);
        offer(1, 1, 1, 1, 1, 1); step(0);
        chk("rst_mid_ov", 64'(bus24.out_valid), 64'd0);
        drain(6);

        // overflow group (10-bit instance wraps or clamps), then a clean group
        for (int i = 0; i < 4; i++) begin
            offer(1, i == 3, 127, 127, 127, 127); step(0);
        end
        offer(1, 1, 1, 2, 3, 4); step(0);
        drain(6);

        // randomized traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            cur_ordy = ($urandom % 4) != 0;
            offer(($urandom % 4) != 0, ($urandom % 3) == 0, rnd(), rnd(), rnd(), rnd());
            step(0);
        end
        for (int i = 0; i < 40 && (q24.size() != 0 || q10.size() != 0 || (cur_v && !accepted)); i++)
            drain(1);
        drain(2);
        chk("drain24", 64'(q24.size()), 64'd0);
        chk("drain10", 64'(q10.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
